// File: rtl/joy_pkg.sv
// Shared types and constants for the Sega-pad scan scheduler.
package joy_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SCAN   = 2'd2
   } joy_state_t;

   localparam int   JOY_STEPS = 8;
   localparam logic PORT_A    = 1'b0;
   localparam logic PORT_B    = 1'b1;

endpackage

// File: rtl/joy_step_timer.sv
// Step/settle cycle counter. Counts up to STEP_CYCLES-1 and wraps to 0.
// A SETTLE interval is made by loading STEP_CYCLES-SETTLE_CYCLES, so the
// same terminal pulse ends it and the first SCAN step starts from 0.
module joy_step_timer #(
   parameter int STEP_CYCLES = 126,
   parameter int READ_POINT  = 120,
   parameter int CW          = $clog2(STEP_CYCLES)
) (
   input  logic          clk28,
   input  logic          rst_n,
   input  logic          run,
   input  logic          ld,
   input  logic [CW-1:0] ld_val,
   output logic          term,
   output logic          rd_pt
);

   logic [CW-1:0] cnt;
   logic          at_end;

   assign at_end = (cnt == CW'(STEP_CYCLES - 1));
   assign term   = run && at_end;
   assign rd_pt  = run && (cnt == CW'(READ_POINT));

   // Counter: load has priority, otherwise count and wrap at the terminal value.
   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n)   cnt <= '0;
      else if (ld)  cnt <= ld_val;
      else if (run) cnt <= at_end ? '0 : cnt + CW'(1);
   end

endmodule

// File: rtl/joy_scan_sched.sv
// Sega-pad time-slot scheduler: one SETTLE + 8-step SEL sequence per connector
// every 128 lines, with commits deferred while the CPU reads the joystick port.
// Build option: define JOY_SCHED_DUAL_PORT_EN to scan ports A and B back to back;
// otherwise only port A is scanned and port_sel / commit[1] stay 0.
module joy_scan_sched #(
   parameter int STEP_CYCLES   = 126,
   parameter int READ_POINT    = 120,
   parameter int SETTLE_CYCLES = 56
) (
   input  logic       clk28,
   input  logic       rst_n,
   input  logic [8:0] vc,
   input  logic [8:0] hc,
   input  logic       enable,
   input  logic       cpu_busy,
   output logic       joy_sel,
   output logic       port_sel,
   output logic [2:0] step,
   output logic       rd_strobe,
   output logic       scan_active,
   output logic [1:0] commit,
   output logic [7:0] overrun_cnt
);
   import joy_pkg::*;

   localparam int CW = $clog2(STEP_CYCLES);
   localparam logic [CW-1:0] SETTLE_LD = CW'(STEP_CYCLES - SETTLE_CYCLES);
`ifdef JOY_SCHED_DUAL_PORT_EN
   localparam bit DUAL = 1'b1;
`else
   localparam bit DUAL = 1'b0;
`endif

   joy_state_t state, state_n;
   logic       trig, port_q, port_n, joy_n, ld, term, rd_pt, done, ovr_inc;
   logic [2:0] step_q, step_n;
   logic [1:0] pend, pend_n, commit_n;

   joy_step_timer #(.STEP_CYCLES(STEP_CYCLES), .READ_POINT(READ_POINT)) u_timer (
      .clk28 (clk28),
      .rst_n (rst_n),
      .run   (state != IDLE),
      .ld    (ld),
      .ld_val(SETTLE_LD),
      .term  (term),
      .rd_pt (rd_pt)
   );

   // Next state, port/step selection and port-end detection.
   always_comb begin
      state_n = state;
      port_n  = port_q;
      step_n  = step_q;
      ld      = 1'b0;
      done    = 1'b0;
      ovr_inc = 1'b0;
      if (!enable) begin
         state_n = IDLE;
         port_n  = PORT_A;
         step_n  = '0;
      end else begin
         case (state)
            IDLE: begin
               port_n = PORT_A;
               if (trig) begin
                  if (!pend[PORT_A]) begin
                     state_n = SETTLE;
                     ld      = 1'b1;
                  end else if (DUAL && !pend[PORT_B]) begin
                     state_n = SETTLE;
                     port_n  = PORT_B;
                     ld      = 1'b1;
                  end else begin
                     ovr_inc = 1'b1;
                  end
               end
            end
            SETTLE: if (term) begin
               state_n = SCAN;
               step_n  = '0;
            end
            SCAN: if (term) begin
               if (step_q == 3'(JOY_STEPS - 1)) begin
                  done   = 1'b1;
                  step_n = '0;
                  if (DUAL && port_q == PORT_A && !pend[PORT_B]) begin
                     state_n = SETTLE;
                     port_n  = PORT_B;
                     ld      = 1'b1;
                  end else begin
                     state_n = IDLE;
                     port_n  = PORT_A;
                  end
               end else begin
                  step_n = step_q + 3'd1;
               end
            end
            default: state_n = IDLE;
         endcase
      end
      if (trig && state != IDLE) ovr_inc = 1'b1;
      joy_n = (state_n == SCAN) && step_n[0];
   end

   // Commit now when the CPU is idle, otherwise hold the port pending until it is.
   always_comb begin
      commit_n = '0;
      pend_n   = '0;
      for (int p = 0; p < 2; p++) begin
         commit_n[p] = !cpu_busy && ((done && port_q == p[0]) || pend[p]);
         pend_n[p]   =  cpu_busy && ((done && port_q == p[0]) || pend[p]);
      end
      if (!DUAL) begin
         commit_n[1] = 1'b0;
         pend_n[1]   = 1'b0;
      end
   end

   // State, outputs and bookkeeping registers.
   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         trig   <= 1'b0;
         port_q <= PORT_A;
         step_q <= '0;
         joy_sel <= 1'b0;
         pend   <= '0;
         commit <= '0;
         overrun_cnt <= '0;
      end else begin
         state  <= state_n;
         trig   <= (vc[6:0] == 7'd0) && (hc == 9'd0) && enable;
         port_q <= port_n;
         step_q <= step_n;
         joy_sel <= joy_n;
         pend   <= pend_n;
         commit <= commit_n;
         if (ovr_inc && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
      end
   end

   assign port_sel    = DUAL ? port_q : PORT_A;
   assign step        = step_q;
   assign scan_active = (state != IDLE);
   assign rd_strobe   = (state == SCAN) && rd_pt;

endmodule

// File: tb/tb_joy_scan_sched.sv
// Directed bench for joy_scan_sched (default and dual-port builds).
module tb_joy_scan_sched;

`ifdef JOY_SCHED_DUAL_PORT_EN
   localparam int DUAL = 1;
`else
   localparam int DUAL = 0;
`endif
   localparam int SCAN_LEN = DUAL ? 2140 : 1075;

   logic       clk28 = 1'b0, rst_n, enable, cpu_busy;
   logic [8:0] vc, hc;
   logic       joy_sel, port_sel, rd_strobe, scan_active;
   logic [2:0] step;
   logic [1:0] commit;
   logic [7:0] overrun_cnt;

   joy_scan_sched dut (
      .clk28(clk28), .rst_n(rst_n), .vc(vc), .hc(hc), .enable(enable),
      .cpu_busy(cpu_busy), .joy_sel(joy_sel), .port_sel(port_sel), .step(step),
      .rd_strobe(rd_strobe), .scan_active(scan_active), .commit(commit),
      .overrun_cnt(overrun_cnt)
   );

   typedef struct { int cyc; int stp; int port; int joy; } ev_t;
   typedef struct { int cyc; int val; } cm_t;
   typedef struct { int off; int stp; int joy; } vec_t;

   ev_t  rd_q[$];
   cm_t  cm_q[$];
   int   rise_q[$];
   int   cyc = 0;
   logic joy_prev = 1'b0;
   int   n_cmp = 0, n_bad = 0;
   vec_t tab[8];

   always #5 clk28 = ~clk28;
   always @(posedge clk28) cyc <= cyc + 1;

   // Event recorder, sampled mid-cycle.
   always @(negedge clk28) begin
      if (rd_strobe) rd_q.push_back('{cyc, int'(step), int'(port_sel), int'(joy_sel)});
      if (commit != 2'b00) cm_q.push_back('{cyc, int'(commit)});
      if (joy_sel && !joy_prev) rise_q.push_back(cyc);
      joy_prev <= joy_sel;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk28);
   endtask

   // Trigger cycle is n0+1; n0 is the cycle hc is held at 0.
   task automatic pulse(input logic [8:0] v, output int n0);
      @(posedge clk28); #1; vc = v; hc = 9'd0; n0 = cyc;
      @(posedge clk28); #1; hc = 9'd1;
   endtask

   task automatic clr_q();
      rd_q.delete(); cm_q.delete(); rise_q.delete();
   endtask

   // Full-scan check against the step table: strobes, commits, first SEL rise.
   task automatic check_scan(input int n0);
      int idx;
      wait_cyc(n0 + SCAN_LEN);
      chk("rd_count", rd_q.size(), 8 * (DUAL + 1));
      for (int p = 0; p <= DUAL; p++)
         for (int i = 0; i < 8; i++) begin
            idx = p * 8 + i;
            if (idx < rd_q.size()) begin
               chk("rd_cyc",  rd_q[idx].cyc,  n0 + tab[i].off + p * 1064);
               chk("rd_step", rd_q[idx].stp,  tab[i].stp);
               chk("rd_port", rd_q[idx].port, p);
               chk("rd_joy",  rd_q[idx].joy,  tab[i].joy);
            end
         end
      chk("commit_count", cm_q.size(), DUAL + 1);
      if (cm_q.size() > 0) begin
         chk("commitA_cyc", cm_q[0].cyc, n0 + 1066);
         chk("commitA_val", cm_q[0].val, 1);
      end
      if (DUAL == 1 && cm_q.size() > 1) begin
         chk("commitB_cyc", cm_q[1].cyc, n0 + 2130);
         chk("commitB_val", cm_q[1].val, 2);
      end
      chk("rise_present", int'(rise_q.size() > 0), 1);
      if (rise_q.size() > 0) chk("first_rise_cyc", rise_q[0], n0 + 184);
      chk("idle_after", int'(scan_active), 0);
      chk("joy_after", int'(joy_sel), 0);
   endtask

   initial begin
      int n0, n1, x, e;
      tab[0] = '{178,  0, 0};
      tab[1] = '{304,  1, 1};
      tab[2] = '{430,  2, 0};
      tab[3] = '{556,  3, 1};
      tab[4] = '{682,  4, 0};
      tab[5] = '{808,  5, 1};
      tab[6] = '{934,  6, 0};
      tab[7] = '{1060, 7, 1};

      rst_n = 1'b0; enable = 1'b0; cpu_busy = 1'b0; vc = 9'd0; hc = 9'd1;
      repeat (3) @(posedge clk28);
      @(negedge clk28);
      chk("rst_joy", int'(joy_sel), 0);
      chk("rst_port", int'(port_sel), 0);
      chk("rst_step", int'(step), 0);
      chk("rst_rd", int'(rd_strobe), 0);
      chk("rst_active", int'(scan_active), 0);
      chk("rst_commit", int'(commit), 0);
      chk("rst_overrun", int'(overrun_cnt), 0);
      @(posedge clk28); #1; rst_n = 1'b1; enable = 1'b1;
      repeat (5) @(posedge clk28);
      @(negedge clk28);
      chk("idle_no_trigger", int'(scan_active), 0);

      // Test 1/2: basic scan, latency, port switch, extra trigger mid-scan.
      clr_q();
      pulse(9'd0, n0);
      chk("trig_cycle_idle", int'(scan_active), 0);
      wait_cyc(n0 + 2);
      chk("settle_active", int'(scan_active), 1);
      chk("settle_joy", int'(joy_sel), 0);
      wait_cyc(n0 + 183);
      chk("step0_joy", int'(joy_sel), 0);
      wait_cyc(n0 + 184);
      chk("step1_joy", int'(joy_sel), 1);
      chk("step1_step", int'(step), 1);
      wait_cyc(n0 + 400);
      pulse(9'd0, n1);
      wait_cyc(n0 + 1065);
      chk("a_end_joy", int'(joy_sel), 1);
      chk("a_end_port", int'(port_sel), 0);
      wait_cyc(n0 + 1066);
      chk("after_a_joy", int'(joy_sel), 0);
      chk("after_a_port", int'(port_sel), DUAL);
      check_scan(n0);
      chk("busy_trig_overrun", int'(overrun_cnt), 1);

      // Test 3/4: commit deferred by cpu_busy; triggers with no eligible port.
      cpu_busy = 1'b1;
      clr_q();
      pulse(9'd0, n0);
      wait_cyc(n0 + SCAN_LEN);
      chk("busy_no_commit", cm_q.size(), 0);
      chk("busy_rd_count", rd_q.size(), 8 * (DUAL + 1));
      pulse(9'd128, n1);
      wait_cyc(n1 + 4);
      chk("skip_overrun", int'(overrun_cnt), 2);
      chk("skip_idle", int'(scan_active), 0);
      for (int k = 0; k < 300; k++) pulse(9'd128, n1);
      wait_cyc(n1 + 4);
      chk("overrun_sat", int'(overrun_cnt), 255);
      chk("pending_no_commit", cm_q.size(), 0);
      @(posedge clk28); #1; cpu_busy = 1'b0; x = cyc;
      wait_cyc(x + 10);
      chk("late_commit_count", cm_q.size(), 1);
      if (cm_q.size() > 0) begin
         chk("late_commit_cyc", cm_q[0].cyc, x + 1);
         chk("late_commit_val", cm_q[0].val, DUAL ? 3 : 1);
      end

      // Test 5: enable drop during step 4, then clean rescan.
      clr_q();
      pulse(9'd0, n0);
      e = n0 + 601;
      wait_cyc(e - 1);
      @(posedge clk28); #1; enable = 1'b0;
      @(negedge clk28);
      chk("abort_same_cycle", int'(scan_active), 1);
      wait_cyc(e + 1);
      chk("abort_active", int'(scan_active), 0);
      chk("abort_joy", int'(joy_sel), 0);
      chk("abort_step", int'(step), 0);
      wait_cyc(n0 + SCAN_LEN);
      chk("abort_no_commit", cm_q.size(), 0);
      chk("abort_rd_count", rd_q.size(), 4);
      @(posedge clk28); #1; enable = 1'b1;
      clr_q();
      pulse(9'd0, n0);
      check_scan(n0);

      // Test 6: asynchronous reset mid-scan.
      clr_q();
      pulse(9'd0, n0);
      wait_cyc(n0 + 500);
      chk("pre_rst_joy", int'(joy_sel), 1);
      @(posedge clk28); #3; rst_n = 1'b0; #1;
      chk("arst_joy", int'(joy_sel), 0);
      chk("arst_step", int'(step), 0);
      chk("arst_active", int'(scan_active), 0);
      chk("arst_overrun", int'(overrun_cnt), 0);
      chk("arst_commit", int'(commit), 0);
      chk("arst_rd", int'(rd_strobe), 0);
      repeat (3) @(posedge clk28);
      #1; rst_n = 1'b1;
      clr_q();
      x = cyc;
      wait_cyc(x + 300);
      chk("post_rst_idle", int'(scan_active), 0);
      chk("post_rst_no_rd", rd_q.size(), 0);
      clr_q();
      pulse(9'd0, n0);
      check_scan(n0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
